seg_scan_decoder: RTL
=====================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: number of consecutive rising edges on which an identical (an, seg) pair must be sampled before a digit is accepted; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 an  input  4  digit enable of a scanned 4-digit display, active-high, one-hot; an[i] selects digit i.
REQ-005 seg  input  7  segment lines, active-high; bit6=a, bit5=b, ..., bit0=g.
REQ-006 value  output  16  last complete decoded frame; digit i in value[4i+3:4i].
REQ-007 valid  output  1  one-cycle pulse marking a new frame on value/digit_err.
REQ-008 digit_err  output  4  per-digit flag: the segment pattern was not a legal hex glyph.

Function
REQ-009 The decode table SHALL be, seg->nibble: 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4, 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9, 1110111->A, 0011111->b, 1001110->C, 0111101->d, 1001111->E, 1000111->F.
REQ-010 Any seg pattern not in REQ-009, including 0000000, SHALL decode to nibble 0 with the error flag set for that digit.
REQ-011 The block SHALL register the previous (an, seg) sample every cycle and keep an 8-bit saturating run counter.
- an one-hot and equal to previous sample: counter increments, saturating at 255.
- an one-hot and differs from previous sample: counter loads 1.
- an not one-hot (0000 or more than one bit set): counter loads 0; no capture.
REQ-012 A digit SHALL be accepted on the edge where the run counter reaches exactly STABLE_CYCLES, i.e. the STABLE_CYCLES-th consecutive edge sampling the same pair.
REQ-013 One dwell SHALL yield at most one acceptance; a held pair is not re-accepted while the counter stays saturated or above STABLE_CYCLES.
REQ-014 On acceptance, the decoded nibble and error flag SHALL be written into internal slot i and bit i of an internal 4-bit capture mask SHALL be set.
REQ-015 A second acceptance of the same digit before frame completion SHALL overwrite slot i (latest wins).
REQ-016 When an acceptance completes the mask (1111), on that same edge:
- all four slots (including the one being written) are copied to value and digit_err;
- valid is pulsed high for exactly one cycle;
- the mask is cleared.
REQ-017 Latency: with inputs stable from edge N, the final digit's frame appears on value and valid is high after edge N+STABLE_CYCLES-1.
REQ-018 value and digit_err SHALL hold their last frame until the next frame completes; valid is 0 on all other cycles.
REQ-019 Scan order is unconstrained; any order that covers all four digits completes a frame.

Reset
REQ-020 While rst=1 at a rising edge, the block SHALL clear value, digit_err, valid, the capture mask, the slots, the run counter and the previous sample to 0.
REQ-021 A reset mid-frame SHALL discard partially captured digits; the first post-reset frame requires all four digits captured after reset.
REQ-022 rst SHALL take priority over any acceptance occurring on the same edge.

Verification
REQ-023 STABLE_CYCLES=4; scan an=0001/0010/0100/1000 with seg=0110000/1101101/1111001/0110011, each held 6 cycles -> value=16'h4321, digit_err=0000, valid high for exactly 1 cycle at edge N+3 of the last dwell.
REQ-024 Same scan but digit 1 held only 3 cycles -> no capture of digit 1, no valid; a later 4-cycle dwell of digit 1 completes the frame.
REQ-025 Digit 2 pattern 0000000, others legal (A,b,C on digits 0,1,3) -> value=16'hC0BA, digit_err=0100.
REQ-026 an=0011 or an=0000 held 20 cycles with a legal seg -> counter stays 0, mask unchanged, no valid.
REQ-027 Digits 0 and 1 captured, then rst pulsed 1 cycle, then a full scan showing F,E,d,C on digits 0..3 -> exactly one valid, value=16'hCDEF.
REQ-028 Digit 0 held 40 cycles showing 5, then 7 on digit 0 for 4 cycles, then digits 1..3 showing 0 -> single capture per dwell, value=16'h0007.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Purpose:
//    Watches the anode/segment lines of a multiplexed 4-digit 7-segment display
//    and reconstructs the 16-bit hex value being shown. A digit is accepted
//    only after the same (an, seg) pair has been sampled on STABLE_CYCLES
//    consecutive rising edges, which filters out scan transitions and ghosting.
//    When all four digits have been captured, the frame is published on
//    value/digit_err and valid pulses for one cycle.
//
// Parameters:
//    STABLE_CYCLES  consecutive identical samples needed to accept a digit
//                   (legal range 2..255)
//
// Ports:
//    clk        in   1   system clock, rising-edge active
//    rst        in   1   synchronous reset, active-high
//    an         in   4   one-hot digit enable, an[i] selects digit i
//    seg        in   7   segment lines, bit6=a ... bit0=g, active-high
//    value      out 16   last complete frame, digit i in value[4i+3:4i]
//    valid      out  1   one-cycle pulse when a new frame is published
//    digit_err  out  4   per-digit flag: pattern was not a legal hex glyph
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an,
   input  logic [6:0]  seg,
   output logic [15:0] value,
   output logic        valid,
   output logic [3:0]  digit_err
);

   // Counter value on the edge *before* acceptance; acceptance happens on the
   // edge that would move the counter from this value to STABLE_CYCLES.
   localparam logic [7:0] ACCEPT_PREV = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_MAX     = 8'hFF;

   // Map a segment pattern to {error, nibble}. Unknown patterns give nibble 0
   // with the error bit set.
   function automatic logic [4:0] decode_glyph(input logic [6:0] pattern);
      logic [4:0] result;
      case (pattern)
         7'b1111110: result = {1'b0, 4'h0};
         7'b0110000: result = {1'b0, 4'h1};
         7'b1101101: result = {1'b0, 4'h2};
         7'b1111001: result = {1'b0, 4'h3};
         7'b0110011: result = {1'b0, 4'h4};
         7'b1011011: result = {1'b0, 4'h5};
         7'b1011111: result = {1'b0, 4'h6};
         7'b1110000: result = {1'b0, 4'h7};
         7'b1111111: result = {1'b0, 4'h8};
         7'b1111011: result = {1'b0, 4'h9};
         7'b1110111: result = {1'b0, 4'hA};
         7'b0011111: result = {1'b0, 4'hB};
         7'b1001110: result = {1'b0, 4'hC};
         7'b0111101: result = {1'b0, 4'hD};
         7'b1001111: result = {1'b0, 4'hE};
         7'b1000111: result = {1'b0, 4'hF};
         default:    result = {1'b1, 4'h0};
      endcase
      return result;
   endfunction

   // True when exactly one bit of the enable vector is set.
   function automatic logic is_one_hot(input logic [3:0] vec);
      logic r;
      case (vec)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // Binary index of a one-hot enable; only meaningful when is_one_hot holds.
   function automatic logic [1:0] digit_index(input logic [3:0] vec);
      logic [1:0] r;
      case (vec)
         4'b0001: r = 2'd0;
         4'b0010: r = 2'd1;
         4'b0100: r = 2'd2;
         4'b1000: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   // State
   logic [3:0]  prev_an_q,   prev_an_d;
   logic [6:0]  prev_seg_q,  prev_seg_d;
   logic [7:0]  run_cnt_q,   run_cnt_d;
   logic [3:0]  mask_q,      mask_d;
   logic [15:0] slot_nib_q,  slot_nib_d;
   logic [3:0]  slot_err_q,  slot_err_d;
   logic [15:0] value_q,     value_d;
   logic [3:0]  digit_err_q, digit_err_d;
   logic        valid_q,     valid_d;

   // Combinational helpers
   logic        an_one_hot_s;
   logic        same_pair_s;
   logic        accept_s;
   logic [4:0]  glyph_s;
   logic [1:0]  idx_s;

   // Run counter and previous-sample tracking.
   always_comb begin
      an_one_hot_s = is_one_hot(an);
      same_pair_s  = (an == prev_an_q) && (seg == prev_seg_q);
      prev_an_d    = an;
      prev_seg_d   = seg;
      if (!an_one_hot_s) begin
         run_cnt_d = 8'd0;
      end else if (same_pair_s) begin
         if (run_cnt_q == CNT_MAX) begin
            run_cnt_d = CNT_MAX;
         end else begin
            run_cnt_d = run_cnt_q + 8'd1;
         end
      end else begin
         run_cnt_d = 8'd1;
      end
      // Accept only on the transition into STABLE_CYCLES so a long dwell (or
      // a saturated counter) never re-triggers.
      accept_s = an_one_hot_s && same_pair_s && (run_cnt_q == ACCEPT_PREV);
   end

   // Slot capture, mask tracking and frame publication.
   always_comb begin
      glyph_s     = decode_glyph(seg);
      idx_s       = digit_index(an);
      slot_nib_d  = slot_nib_q;
      slot_err_d  = slot_err_q;
      mask_d      = mask_q;
      value_d     = value_q;
      digit_err_d = digit_err_q;
      valid_d     = 1'b0;
      if (accept_s) begin
         case (idx_s)
            2'd0:    slot_nib_d[3:0]   = glyph_s[3:0];
            2'd1:    slot_nib_d[7:4]   = glyph_s[3:0];
            2'd2:    slot_nib_d[11:8]  = glyph_s[3:0];
            2'd3:    slot_nib_d[15:12] = glyph_s[3:0];
            default: slot_nib_d        = slot_nib_q;
         endcase
         slot_err_d[idx_s] = glyph_s[4];
         mask_d[idx_s]     = 1'b1;
         // The digit being written this edge is already folded into the
         // *_d copies, so the published frame includes it.
         if (mask_d == 4'b1111) begin
            value_d     = slot_nib_d;
            digit_err_d = slot_err_d;
            valid_d     = 1'b1;
            mask_d      = 4'b0000;
         end else begin
            valid_d     = 1'b0;
         end
      end else begin
         valid_d = 1'b0;
      end
   end

   // State registers; reset wins over any same-edge acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_an_q   <= 4'd0;
         prev_seg_q  <= 7'd0;
         run_cnt_q   <= 8'd0;
         mask_q      <= 4'd0;
         slot_nib_q  <= 16'd0;
         slot_err_q  <= 4'd0;
         value_q     <= 16'd0;
         digit_err_q <= 4'd0;
         valid_q     <= 1'b0;
      end else begin
         prev_an_q   <= prev_an_d;
         prev_seg_q  <= prev_seg_d;
         run_cnt_q   <= run_cnt_d;
         mask_q      <= mask_d;
         slot_nib_q  <= slot_nib_d;
         slot_err_q  <= slot_err_d;
         value_q     <= value_d;
         digit_err_q <= digit_err_d;
         valid_q     <= valid_d;
      end
   end

   assign value     = value_q;
   assign digit_err = digit_err_q;
   assign valid     = valid_q;

endmodule
